mc_control_fsm: RTL

Parametrised multi-cycle control unit, the next generation of the core's control FSM. Adds variable-latency instruction and data memory handshakes (req/ready) with per-access wait-state timeout, an illegal-instruction/timeout FAULT state, and a one-cycle retire strobe. Sits between the IR/ALU-flag datapath and the multi-cycle datapath mux/enable inputs.

---
 rtl/mc_control_fsm.sv | 364 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multi-cycle control unit with variable-latency memory
// handshakes.
//
// Sequences IF -> ID -> EX -> [MEM] -> [WB] for the supported instruction set,
// stalling in IF/MEM until the matching memory reports ready. A stall longer than
// WAIT_MAX cycles, or an undecodable instruction, parks the unit in FAULT until
// reset.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   opcode, funct        IR fields
//   zero                 ALU zero flag (BEQ resolution)
//   imem_ready           instruction memory data valid
//   dmem_ready           data memory read valid / write accepted
//   imem_req, dmem_req   memory access requests
//   *_flag               datapath enables/selects
//   alu_op               ALU operation
//   alu_src_a/alu_src_b  ALU operand selects
//   pc_src               PC source select
//   instr_done           one-cycle retire strobe
//   fault                high while in FAULT
//   state_o              state encoding, for debug
//   cycle_cnt            (PERF_CNT_EN only) cycles spent outside FAULT
//   retired_cnt          (PERF_CNT_EN only) retired instructions
//
// Optional build macro: PERF_CNT_EN adds the cycle/retire counters.

`ifndef ALU_OPCODE
`define ALU_OPCODE 3:0
`endif
`ifndef ALU_AND
`define ALU_AND 4'd0
`endif
`ifndef ALU_OR
`define ALU_OR 4'd1
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd2
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd6
`endif
`ifndef ALU_DEFAULT
`define ALU_DEFAULT `ALU_ADD
`endif
`ifndef ALU_SRC_A
`define ALU_SRC_A 0:0
`endif
`ifndef ALU_SRC_A_PC
`define ALU_SRC_A_PC 1'b0
`endif
`ifndef ALU_SRC_A_REG1
`define ALU_SRC_A_REG1 1'b1
`endif
`ifndef ALU_SRC_B
`define ALU_SRC_B 1:0
`endif
`ifndef ALU_SRC_B_REG2
`define ALU_SRC_B_REG2 2'd0
`endif
`ifndef ALU_SRC_B_FOUR
`define ALU_SRC_B_FOUR 2'd1
`endif
`ifndef ALU_SRC_B_IMM
`define ALU_SRC_B_IMM 2'd2
`endif
`ifndef PC_SRC
`define PC_SRC 1:0
`endif
`ifndef PC_SRC_ALU
`define PC_SRC_ALU 2'd0
`endif
`ifndef PC_SRC_ALU_OUT
`define PC_SRC_ALU_OUT 2'd1
`endif
`ifndef PC_SRC_JUMP
`define PC_SRC_JUMP 2'd2
`endif

module mc_control_fsm #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned FUNCT_W  = 6,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                reg_dst_flag,
    output logic                alu_src_flag,
    output logic                mem_to_reg_flag,
    output logic                reg_write_flag,
    output logic                mem_read_flag,
    output logic                mem_write_flag,
    output logic                branch_flag,
    output logic                jump_flag,
    output logic                pc_write_flag,
    output logic                ir_write_flag,
    output logic                alu_out_write_flag,
    output logic                mem_data_write_flag,
    output logic                reg_data_write_flag,
    output logic [`ALU_OPCODE]  alu_op,
    output logic [`ALU_SRC_A]   alu_src_a,
    output logic [`ALU_SRC_B]   alu_src_b,
    output logic [`PC_SRC]      pc_src,
    output logic                instr_done,
    output logic                fault,
`ifdef PERF_CNT_EN
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         retired_cnt,
`endif
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EX    = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_FAULT = 3'd7
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);

    localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Instruction decode
    logic             is_r, is_j, is_beq, is_addi, is_ori, is_lw, is_sw;
    logic             funct_ok, legal;
    logic [`ALU_OPCODE] r_alu_op;

    // ALU setup chosen in EX; WB presents the same values so the ALU result
    // stays stable while it is written back.
    logic [`ALU_OPCODE] ex_alu_op;
    logic [`ALU_SRC_B]  ex_src_b;
    logic               ex_alu_src;

    always_comb begin
        is_r    = (opcode == OP_R);
        is_j    = (opcode == OP_J);
        is_beq  = (opcode == OP_BEQ);
        is_addi = (opcode == OP_ADDI);
        is_ori  = (opcode == OP_ORI);
        is_lw   = (opcode == OP_LW);
        is_sw   = (opcode == OP_SW);

        funct_ok = 1'b1;
        r_alu_op = `ALU_ADD;
        case (funct)
            FN_ADD:  r_alu_op = `ALU_ADD;
            FN_SUB:  r_alu_op = `ALU_SUB;
            FN_AND:  r_alu_op = `ALU_AND;
            FN_OR:   r_alu_op = `ALU_OR;
            default: funct_ok = 1'b0;
        endcase

        legal = (is_r & funct_ok) | is_j | is_beq | is_addi | is_ori | is_lw | is_sw;

        ex_alu_op  = `ALU_ADD;
        ex_src_b   = `ALU_SRC_B_IMM;
        ex_alu_src = 1'b1;
        if (is_r) begin
            ex_alu_op  = r_alu_op;
            ex_src_b   = `ALU_SRC_B_REG2;
            ex_alu_src = 1'b0;
        end else if (is_beq) begin
            ex_alu_op  = `ALU_SUB;
            ex_src_b   = `ALU_SRC_B_REG2;
            ex_alu_src = 1'b0;
        end else if (is_ori) begin
            ex_alu_op  = `ALU_OR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IF;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        wait_cnt_d          = wait_cnt_q;
        imem_req            = 1'b0;
        dmem_req            = 1'b0;
        reg_dst_flag        = 1'b0;
        alu_src_flag        = 1'b0;
        mem_to_reg_flag     = 1'b0;
        reg_write_flag      = 1'b0;
        mem_read_flag       = 1'b0;
        mem_write_flag      = 1'b0;
        branch_flag         = 1'b0;
        jump_flag           = 1'b0;
        pc_write_flag       = 1'b0;
        ir_write_flag       = 1'b0;
        alu_out_write_flag  = 1'b0;
        mem_data_write_flag = 1'b0;
        reg_data_write_flag = 1'b0;
        alu_op              = `ALU_DEFAULT;
        alu_src_a           = `ALU_SRC_A_PC;
        alu_src_b           = `ALU_SRC_B_FOUR;
        pc_src              = `PC_SRC_ALU;
        instr_done          = 1'b0;
        fault               = 1'b0;

        // Outputs are forced to defaults while rst is high so an in-flight
        // memory request drops in the same cycle reset arrives.
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write_flag = 1'b1;
                        pc_write_flag = 1'b1;
                        state_d       = S_ID;
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d = S_FAULT;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end

                S_ID: begin
                    reg_data_write_flag = 1'b1;
                    if (!legal) begin
                        state_d = S_FAULT;
                    end else if (is_j) begin
                        jump_flag     = 1'b1;
                        pc_write_flag = 1'b1;
                        pc_src        = `PC_SRC_JUMP;
                        instr_done    = 1'b1;
                        state_d       = S_IF;
                    end else begin
                        state_d = S_EX;
                    end
                end

                S_EX: begin
                    alu_out_write_flag = 1'b1;
                    alu_src_a          = `ALU_SRC_A_REG1;
                    alu_src_b          = ex_src_b;
                    alu_src_flag       = ex_alu_src;
                    alu_op             = ex_alu_op;
                    if (is_beq) begin
                        alu_out_write_flag = 1'b0;
                        branch_flag        = 1'b1;
                        pc_write_flag      = zero;
                        instr_done         = 1'b1;
                        state_d            = S_IF;
                    end else if (is_r && funct_ok) begin
                        reg_dst_flag = 1'b1;
                        state_d      = S_WB;
                    end else if (is_addi || is_ori) begin
                        state_d = S_WB;
                    end else if (is_lw || is_sw) begin
                        state_d = S_MEM;
                    end else begin
                        state_d = S_FAULT;
                    end
                end

                S_MEM: begin
                    dmem_req       = 1'b1;
                    mem_read_flag  = is_lw;
                    mem_write_flag = is_sw;
                    if (dmem_ready) begin
                        if (is_lw) begin
                            mem_data_write_flag = 1'b1;
                            state_d             = S_WB;
                        end else begin
                            instr_done = 1'b1;
                            state_d    = S_IF;
                        end
                    end else if (wait_cnt_q == WAIT_LIMIT) begin
                        state_d = S_FAULT;
                    end else if (wait_cnt_q != '1) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end

                S_WB: begin
                    reg_write_flag  = 1'b1;
                    mem_to_reg_flag = is_lw;
                    reg_dst_flag    = is_r;
                    alu_src_a       = `ALU_SRC_A_REG1;
                    alu_src_b       = ex_src_b;
                    alu_src_flag    = ex_alu_src;
                    alu_op          = ex_alu_op;
                    instr_done      = 1'b1;
                    state_d         = S_IF;
                end

                S_FAULT: begin
                    fault = 1'b1;
                end

                default: begin
                    state_d = S_FAULT;
                end
            endcase

            if (state_d != state_q) begin
                wait_cnt_d = '0;
            end
        end
    end

    assign state_o = state_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if (state_q != S_FAULT) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (instr_done) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule
